// File: rtl/noc_pkt_pkg.sv
// Shared NoC packet definitions for the traffic source and sink BFMs.
// Flit layout, MSB->LSB:
//   pad_n[NA] | pad_vc[VA] | src_node[NA] | dest[NA] | vc[VA] | id[8] | cnt[DCW]
// with NA = $clog2(N), VA = $clog2(NUM_VC), DCW = WIDTH - 3*NA - 2*VA - 8.
package noc_pkt_pkg;

  localparam int unsigned ID_W = 8;

  // Bit positions inside the sticky err_flags vector.
  localparam int unsigned ERR_PAD   = 0;
  localparam int unsigned ERR_ROUTE = 1;
  localparam int unsigned ERR_ID    = 2;
  localparam int unsigned ERR_ORDER = 3;

  function automatic int unsigned na_w(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned va_w(input int unsigned num_vc);
    return $clog2(num_vc);
  endfunction

  function automatic int unsigned dcw_w(input int unsigned width,
                                        input int unsigned na,
                                        input int unsigned va);
    return width - 3 * na - 2 * va - ID_W;
  endfunction

  // Field LSB offsets, given the data-counter width and address widths.
  function automatic int unsigned id_lsb(input int unsigned dcw);
    return dcw;
  endfunction

  function automatic int unsigned vc_lsb(input int unsigned dcw);
    return dcw + ID_W;
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned dcw, input int unsigned va);
    return dcw + ID_W + va;
  endfunction

  function automatic int unsigned src_lsb(input int unsigned dcw, input int unsigned na,
                                          input int unsigned va);
    return dcw + ID_W + va + na;
  endfunction

  function automatic int unsigned pad_vc_lsb(input int unsigned dcw, input int unsigned na,
                                             input int unsigned va);
    return dcw + ID_W + va + 2 * na;
  endfunction

  function automatic int unsigned pad_n_lsb(input int unsigned dcw, input int unsigned na,
                                            input int unsigned va);
    return dcw + ID_W + 2 * va + 2 * na;
  endfunction

  // Packed view for the default configuration (WIDTH=32, N=16, NUM_VC=2).
  localparam int unsigned DEF_NA  = 4;
  localparam int unsigned DEF_VA  = 1;
  localparam int unsigned DEF_DCW = 10;

  typedef struct packed {
    logic [DEF_NA-1:0]  pad_n;
    logic [DEF_VA-1:0]  pad_vc;
    logic [DEF_NA-1:0]  src_node;
    logic [DEF_NA-1:0]  dest;
    logic [DEF_VA-1:0]  vc;
    logic [ID_W-1:0]    id;
    logic [DEF_DCW-1:0] cnt;
  } flit_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } snk_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; advances every cycle.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset, loads seed
//   seed in   16-bit nonzero seed
//   out  out  current LFSR state
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= seed;
    end else begin
      out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
    end
  end

endmodule

// File: rtl/sink_checker.sv
// NoC output-port traffic sink/checker. Accepts flits over valid/ready with
// optional pseudo-random backpressure, checks padding, routing, source id and
// per-source count ordering, and keeps sticky error flags and saturating counters.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   data_in     flit (layout in noc_pkt_pkg)
//   vc_in       VC the flit arrived on
//   valid_in    flit valid
//   ready_out   registered ready
//   done        sticky, rx_count >= NUM_EXPECTED
//   error       sticky, any check failed
//   err_flags   sticky {order, id, route, pad}
//   rx_count    accepted flits, saturating
//   err_count   flits with at least one failed check, saturating
module sink_checker
  import noc_pkt_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned N             = 16,
  parameter int unsigned NUM_VC        = 2,
  parameter int unsigned N_ADDR_WIDTH  = $clog2(N),
  parameter int unsigned VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter int unsigned NODE          = 0,
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned NUM_EXPECTED  = 1000,
  parameter int unsigned STALL_EN      = 0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [VC_ADDR_WIDTH-1:0] vc_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic                     done,
  output logic                     error,
  output logic [3:0]               err_flags,
  output logic [31:0]              rx_count,
  output logic [15:0]              err_count
);

  localparam int unsigned NA  = N_ADDR_WIDTH;
  localparam int unsigned VA  = VC_ADDR_WIDTH;
  localparam int unsigned DCW = dcw_w(WIDTH, NA, VA);

  localparam int unsigned ID_LSB   = id_lsb(DCW);
  localparam int unsigned VC_LSB   = vc_lsb(DCW);
  localparam int unsigned DEST_LSB = dest_lsb(DCW, VA);
  localparam int unsigned SRC_LSB  = src_lsb(DCW, NA, VA);
  localparam int unsigned PVC_LSB  = pad_vc_lsb(DCW, NA, VA);
  localparam int unsigned PN_LSB   = pad_n_lsb(DCW, NA, VA);

  // Field decode
  logic [DCW-1:0]  f_cnt;
  logic [ID_W-1:0] f_id;
  logic [VA-1:0]   f_vc;
  logic [NA-1:0]   f_dest;
  logic [NA-1:0]   f_src;
  logic [VA-1:0]   f_pad_vc;
  logic [NA-1:0]   f_pad_n;

  always_comb begin
    f_cnt    = data_in[DCW-1:0];
    f_id     = data_in[ID_LSB   +: ID_W];
    f_vc     = data_in[VC_LSB   +: VA];
    f_dest   = data_in[DEST_LSB +: NA];
    f_src    = data_in[SRC_LSB  +: NA];
    f_pad_vc = data_in[PVC_LSB  +: VA];
    f_pad_n  = data_in[PN_LSB   +: NA];
  end

  // src_node is not checked; it is only carried for trace purposes.
  logic unused_src;
  assign unused_src = ^f_src;

  // Backpressure
  logic [15:0] lfsr_q;
  logic        ready_d;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .out  (lfsr_q)
  );

  assign ready_d     = (STALL_EN != 0) ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
  assign unused_lfsr = ^lfsr_q[15:2];

  // Per-source ordering state
  logic [DCW-1:0]     last_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] seen;
  logic [DCW-1:0]     sel_last;
  logic               sel_seen;

  always_comb begin
    sel_last = '0;
    sel_seen = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (f_id == ID_W'(i)) begin
        sel_last = last_cnt[i];
        sel_seen = seen[i];
      end
    end
  end

  // Checks
  logic       accept;
  logic       id_legal;
  logic [3:0] fail;

  always_comb begin
    accept   = valid_in & ready_out;
    id_legal = (32'(f_id) < NUM_SRC);
    fail     = '0;
    fail[ERR_PAD]   = (f_pad_n != '0) || (f_pad_vc != '0);
    fail[ERR_ROUTE] = (f_dest != NA'(NODE)) || (f_vc != vc_in);
    fail[ERR_ID]    = !id_legal;
    fail[ERR_ORDER] = id_legal && (sel_seen ? !(f_cnt > sel_last) : (f_cnt == '0));
  end

  logic [31:0] rx_next;
  assign rx_next = (accept && (rx_count != '1)) ? rx_count + 32'd1 : rx_count;

  // FSM
  snk_state_t state, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   if (rx_next >= 32'(NUM_EXPECTED)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RESET;
    endcase
  end

  assign done  = (state == ST_DONE);
  assign error = |err_flags;

  // Datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_out <= 1'b0;
      rx_count  <= '0;
      err_count <= '0;
      err_flags <= '0;
      seen      <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        last_cnt[i] <= '0;
      end
    end else begin
      ready_out <= ready_d;
      rx_count  <= rx_next;
      if (accept) begin
        err_flags <= err_flags | fail;
        if ((fail != '0) && (err_count != '1)) begin
          err_count <= err_count + 16'd1;
        end
        // History updates even when the order check fails.
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (id_legal && (f_id == ID_W'(i))) begin
            last_cnt[i] <= f_cnt;
            seen[i]     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sink_checker.sv
module tb_sink_checker;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] data0, data1;
  logic        vc0, vc1;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic        done0, done1;
  logic        error0, error1;
  logic [3:0]  flags0, flags1;
  logic [31:0] rx0, rx1;
  logic [15:0] ec0, ec1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sink_checker #(
    .WIDTH(32), .N(16), .NUM_VC(2), .NODE(5), .NUM_SRC(4),
    .NUM_EXPECTED(1000), .STALL_EN(0), .LFSR_SEED(16'hACE1)
  ) dut0 (
    .clk(clk), .rst(rst), .data_in(data0), .vc_in(vc0), .valid_in(valid0),
    .ready_out(ready0), .done(done0), .error(error0), .err_flags(flags0),
    .rx_count(rx0), .err_count(ec0)
  );

  sink_checker #(
    .WIDTH(32), .N(16), .NUM_VC(2), .NODE(5), .NUM_SRC(4),
    .NUM_EXPECTED(20), .STALL_EN(1), .LFSR_SEED(16'hACE1)
  ) dut1 (
    .clk(clk), .rst(rst), .data_in(data1), .vc_in(vc1), .valid_in(valid1),
    .ready_out(ready1), .done(done1), .error(error1), .err_flags(flags1),
    .rx_count(rx1), .err_count(ec1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] pn, input logic pvc,
                                     input logic [3:0] src, input logic [3:0] dest,
                                     input logic vc, input logic [7:0] id,
                                     input logic [9:0] cnt);
    return {pn, pvc, src, dest, vc, id, cnt};
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference model of dut0
  logic [9:0] m_last [4];
  logic       m_seen [4];
  int         m_rx;
  int         m_ec;
  logic [3:0] m_fl;

  typedef struct {
    int         rx;
    int         ec;
    logic [3:0] fl;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    m_rx = 0;
    m_ec = 0;
    m_fl = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_last[i] = 10'd0;
      m_seen[i] = 1'b0;
    end
  endtask

  task automatic send(input string tag, input logic [3:0] pn, input logic pvc,
                      input logic [3:0] dest, input logic vc, input logic [7:0] id,
                      input logic [9:0] cnt, input logic vcin);
    logic [3:0] f;
    exp_t e;
    data0  = mk(pn, pvc, id[3:0], dest, vc, id, cnt);
    vc0    = vcin;
    valid0 = 1'b1;
    chk({tag, "/ready"}, {31'd0, ready0}, 32'd1);
    f    = 4'b0000;
    f[0] = (pn != 4'd0) || pvc;
    f[1] = (dest != 4'd5) || (vc != vcin);
    f[2] = (id >= 8'd4);
    if (id < 8'd4) begin
      f[3] = m_seen[id[1:0]] ? (cnt <= m_last[id[1:0]]) : (cnt == 10'd0);
      m_last[id[1:0]] = cnt;
      m_seen[id[1:0]] = 1'b1;
    end
    m_rx++;
    if (f != 4'b0000) m_ec++;
    m_fl = m_fl | f;
    sb.push_back('{m_rx, m_ec, m_fl});
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    e = sb.pop_front();
    chk({tag, "/rx"},    rx0, e.rx);
    chk({tag, "/ec"},    {16'd0, ec0}, e.ec);
    chk({tag, "/flags"}, {28'd0, flags0}, {28'd0, e.fl});
    chk({tag, "/error"}, {31'd0, error0}, {31'd0, (e.fl != 4'b0000)});
  endtask

  task automatic do_reset(input string tag);
    rst    = 1'b1;
    valid0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "/ready_low"}, {31'd0, ready0}, 32'd0);
    chk({tag, "/rx"},        rx0, 32'd0);
    chk({tag, "/ec"},        {16'd0, ec0}, 32'd0);
    chk({tag, "/flags"},     {28'd0, flags0}, 32'd0);
    chk({tag, "/done"},      {31'd0, done0}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/ready_high"}, {31'd0, ready0}, 32'd1);
    model_reset();
  endtask

  initial begin
    rst    = 1'b1;
    data0  = '0; data1 = '0;
    vc0    = 1'b0; vc1 = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    model_reset();

    // 1: clean stream from id 2
    do_reset("rst1");
    for (int c = 1; c <= 3; c++) send("t1", 4'd0, 1'b0, 4'd5, 1'b1, 8'd2, 10'(c), 1'b1);

    // 2: misrouted flit, then a good one
    send("t2_bad",  4'd0, 1'b0, 4'd7, 1'b1, 8'd2, 10'd4, 1'b1);
    send("t2_good", 4'd0, 1'b0, 4'd5, 1'b1, 8'd2, 10'd5, 1'b1);

    // 3: ordering on id 1
    send("t3_9", 4'd0, 1'b0, 4'd5, 1'b0, 8'd1, 10'd9, 1'b0);
    send("t3_4", 4'd0, 1'b0, 4'd5, 1'b0, 8'd1, 10'd4, 1'b0);
    send("t3_5", 4'd0, 1'b0, 4'd5, 1'b0, 8'd1, 10'd5, 1'b0);

    // 4: multiple failures on one flit
    do_reset("rst4");
    send("t4", 4'd3, 1'b0, 4'd2, 1'b1, 8'd6, 10'd1, 1'b1);
    chk("t4/flags_exact", {28'd0, flags0}, 32'h7);
    chk("t4/ec_exact",    {16'd0, ec0},    32'd1);

    // 6: reset mid-stream with a flit in flight
    do_reset("rst6a");
    for (int c = 1; c <= 10; c++) send("t6_pre", 4'd0, 1'b0, 4'd5, 1'b1, 8'd0, 10'(c), 1'b1);
    chk("t6/rx10", rx0, 32'd10);
    data0  = mk(4'd0, 1'b0, 4'd0, 4'd7, 1'b1, 8'd0, 10'd0);
    vc0    = 1'b1;
    valid0 = 1'b1;
    rst    = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    chk("t6/rx_cleared",    rx0, 32'd0);
    chk("t6/flags_cleared", {28'd0, flags0}, 32'd0);
    chk("t6/ready_low",     {31'd0, ready0}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6/ready_high", {31'd0, ready0}, 32'd1);
    model_reset();
    send("t6_post", 4'd0, 1'b0, 4'd5, 1'b1, 8'd0, 10'd1, 1'b1);

    // 5: LFSR backpressure on dut1
    begin
      logic [15:0] m;
      logic        prev_ready, r_exp, acc;
      int          cnt1;
      rst    = 1'b1;
      valid1 = 1'b1;
      vc1    = 1'b1;
      data1  = mk(4'd0, 1'b0, 4'd3, 4'd5, 1'b1, 8'd3, 10'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t5/ready_rst", {31'd0, ready1}, 32'd0);
      chk("t5/rx_rst",    rx1, 32'd0);
      rst        = 1'b0;
      m          = 16'hACE1;
      prev_ready = 1'b0;
      cnt1       = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk);
        acc   = prev_ready;
        r_exp = m[0] | m[1];
        m     = lstep(m);
        #1;
        if (acc) begin
          cnt1++;
          data1 = mk(4'd0, 1'b0, 4'd3, 4'd5, 1'b1, 8'd3, 10'(cnt1 + 1));
        end
        chk("t5/ready", {31'd0, ready1}, {31'd0, r_exp});
        chk("t5/rx",    rx1, cnt1);
        chk("t5/done",  {31'd0, done1}, {31'd0, (cnt1 >= 20)});
        prev_ready = r_exp;
      end
      valid1 = 1'b0;
      chk("t5/reached", {31'd0, (cnt1 >= 20)}, 32'd1);
      chk("t5/ec",      {16'd0, ec1}, 32'd0);
      chk("t5/flags",   {28'd0, flags1}, 32'd0);
      chk("t5/error",   {31'd0, error1}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
